// File: rtl/pmod_als_responder.sv
// rtl/pmod_als_responder.sv - PmodALS (ADC081S021-framed) SPI responder; ALS_RESP_FRAME_CHECK_EN adds frame_err
module pmod_als_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int LEAD_ZEROS  = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             sck,
  output logic             sdo,
  input  logic [7:0]       sample_in,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - 8;
  localparam int BW    = $clog2(FRAME_BITS + 2);
  localparam logic [BW-1:0] BIT_SAT  = BW'(FRAME_BITS + 1);
  localparam logic [BW-1:0] BIT_FULL = BW'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Index 0 is the newest sample; the top index is one history flop past the synchronizer.
  logic [SYNC_STAGES:0] cs_sync, sck_sync, fill;
  logic                 armed, pend;
  logic                 cs_fall, cs_rise, sck_fall;
  state_t               state;
  logic [FRAME_BITS-1:0] shreg;
  logic [BW-1:0]        bitcnt;

  assign cs_fall  =  cs_sync[SYNC_STAGES]  & ~cs_sync[SYNC_STAGES-1];
  assign cs_rise  = ~cs_sync[SYNC_STAGES]  &  cs_sync[SYNC_STAGES-1];
  assign sck_fall =  sck_sync[SYNC_STAGES] & ~sck_sync[SYNC_STAGES-1];

  // fill marks when the chain holds real pin samples rather than reset ones,
  // so a cs held low through reset release never arms the responder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync  <= '1;
      sck_sync <= '1;
      fill     <= '0;
      armed    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-1:0], cs};
      sck_sync <= {sck_sync[SYNC_STAGES-1:0], sck};
      fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
      if (fill[SYNC_STAGES] && cs_sync[SYNC_STAGES])
        armed <= 1'b1;
    end
  end

`ifdef ALS_RESP_FRAME_CHECK_EN
  logic frame_err_r;
  assign frame_err = frame_err_r;
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      sdo        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      pend       <= 1'b0;
`ifdef ALS_RESP_FRAME_CHECK_EN
      frame_err_r <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifdef ALS_RESP_FRAME_CHECK_EN
      frame_err_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if ((cs_fall && armed) || pend) begin
            state  <= SHIFT;
            shreg  <= FRAME_BITS'(sample_in) << TRAIL;
            bitcnt <= '0;
            sdo    <= 1'b0;
            busy   <= 1'b1;
            pend   <= 1'b0;
          end
        end
        SHIFT: begin
          // A sck fall coinciding with cs_rise belongs to no frame and is dropped.
          if (cs_rise) begin
            state      <= DONE;
            sdo        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
`ifdef ALS_RESP_FRAME_CHECK_EN
            frame_err_r <= (bitcnt != BIT_FULL);
`endif
          end else if (sck_fall) begin
            sdo   <= shreg[FRAME_BITS-1];
            shreg <= shreg << 1;
            if (bitcnt != BIT_SAT)
              bitcnt <= bitcnt + BW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          frame_cnt <= frame_cnt + CNT_W'(1);
          if (cs_fall && armed)
            pend <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_als_responder.sv
// tb/tb_pmod_als_responder.sv - scoreboard bench for pmod_als_responder
module tb_pmod_als_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1;
  logic        sck = 1'b1;
  logic [7:0]  sample_in = 8'h00;
  logic        sdo, busy, frame_done, frame_err;
  logic [15:0] frame_cnt;

  pmod_als_responder dut (
    .clk(clk), .rst(rst), .cs(cs), .sck(sck), .sdo(sdo),
    .sample_in(sample_in), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          nb;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] cap;
  int          cap_n;
  logic [15:0] cnt_model = 16'd0;
  logic        cnt_pend = 1'b0;
  logic [15:0] cnt_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every frame_done must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (cnt_pend) begin
        chk("frame_cnt", 32'(frame_cnt), 32'(cnt_exp));
        cnt_pend = 1'b0;
      end
      if (frame_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("frame_word", cap, e.word);
          chk("frame_bits", 32'(cap_n), 32'(e.nb));
          chk("sdo_at_done", 32'(sdo), 32'd0);
`ifdef ALS_RESP_FRAME_CHECK_EN
          chk("frame_err", 32'(frame_err), 32'(e.err));
`else
          chk("frame_err", 32'(frame_err), 32'd0);
`endif
          cnt_exp  = e.cnt;
          cnt_pend = 1'b1;
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_frame(input int nf, input logic [7:0] s, input logic [7:0] s2,
                          input logic [31:0] word, input logic err);
    exp_t e;
    cnt_model = cnt_model + 16'd1;
    e.word = word; e.nb = nf; e.err = err; e.cnt = cnt_model;
    sb.push_back(e);
    sample_in = s;
    chk("busy_before", 32'(busy), 32'd0);
    cap = '0;
    cap_n = 0;
    cs = 1'b0;
    wait_clk(6);
    sample_in = s2;
    wait_clk(2);
    for (int i = 0; i < nf; i++) begin
      sck = 1'b0;
      wait_clk(8);
      sck = 1'b1;
      cap = {cap[30:0], sdo};
      cap_n++;
      if (i == 1) chk("busy_mid", 32'(busy), 32'd1);
      wait_clk(8);
    end
    wait_clk(2);
    cs = 1'b1;
    wait_clk(12);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(4);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    wait_clk(10);

    do_frame(16, 8'hA5, 8'hA5, 32'h14A0, 1'b0);
    do_frame(16, 8'hA5, 8'h3C, 32'h14A0, 1'b0);
    do_frame(16, 8'h3C, 8'h3C, 32'h0780, 1'b0);
    do_frame(16, 8'hFF, 8'hFF, 32'h1FE0, 1'b0);
    do_frame(16, 8'h00, 8'h00, 32'h0000, 1'b0);
    do_frame(10, 8'hA5, 8'hA5, 32'h0052, 1'b1);
    do_frame(20, 8'hA5, 8'hA5, 32'h14A00, 1'b1);

    // Reset in the middle of a frame, released while cs is still low.
    sample_in = 8'hA5;
    cs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 3; i++) begin
      sck = 1'b0; wait_clk(8); sck = 1'b1; wait_clk(8);
    end
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    cnt_model = 16'd0;
    for (int i = 0; i < 4; i++) begin
      sck = 1'b0; wait_clk(8); sck = 1'b1;
      chk("post_rst_sdo", 32'(sdo), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      wait_clk(8);
    end
    chk("post_rst_cnt", 32'(frame_cnt), 32'd0);
    cs = 1'b1;
    wait_clk(10);
    do_frame(16, 8'h5A, 8'h5A, 32'h0B40, 1'b0);

    wait_clk(5);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
